// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-store FIFO and blocking load path to a slow dmem.
// Define STORE_FORWARD_EN to forward buffered stores to loads with zero stall.
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR, RD, RWAIT} state_e;
  state_e state_q, state_d;

  logic [29:0]   fa_q [DEPTH];
  logic [31:0]   fd_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic        pend_q, pend_d;
  logic        done_q, done_d;
  logic [31:0] ld_data_q, ld_data_d;

  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;

  logic        full, push, pop, hit;
  logic        load_need, rd_want, rd_go, wr_go;
  logic [31:0] fwd_data;
  logic [29:0] hd_addr;
  logic [31:0] hd_data;
  logic        unused_addr;

  assign unused_addr = ^addr[1:0];

  assign full = (count_q == CW'(DEPTH));
  assign push = mem_write & ~full;
  assign pop  = (state_q == WR) & m_ready;

  // An empty FIFO lets a same-cycle store go straight to the write port
  assign hd_addr = (count_q == '0) ? addr[31:2] : fa_q[head_q];
  assign hd_data = (count_q == '0) ? write_data : fd_q[head_q];

`ifdef STORE_FORWARD_EN
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q &&
          fa_q[head_q + PW'(i)] == addr[31:2]) begin
        hit      = 1'b1;
        fwd_data = fd_q[head_q + PW'(i)];
      end
    end
  end
  assign rd_go = rd_want;
`else
  assign hit      = 1'b0;
  assign fwd_data = '0;
  assign rd_go    = rd_want & (count_q == '0);
`endif

  assign load_need = mem_read & ~done_q & ~hit;
  assign rd_want   = ~done_q & (pend_q | load_need);
  assign wr_go     = (count_q != '0) | push;

  assign stall = rst & ((mem_write & full) | load_need);

  always_comb begin
    read_data = '0;
    if (rst && mem_read) begin
      if (done_q)   read_data = ld_data_q;
      else if (hit) read_data = fwd_data;
    end
  end

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
  end

  always_comb begin
    pend_d    = pend_q;
    done_d    = done_q;
    ld_data_d = ld_data_q;
    if (mem_read && done_q) begin
      pend_d = 1'b0;
      done_d = 1'b0;
    end else if (load_need) begin
      pend_d = 1'b1;
    end
    if (state_q == RWAIT && m_rvalid) begin
      done_d    = 1'b1;
      ld_data_d = m_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      ld_data_q <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      ld_data_q <= ld_data_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[tail_q] <= addr[31:2];
      fd_q[tail_q] <= write_data;
    end
  end

  // Loads take priority over draining stores
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rd_go)      state_d = RD;
        else if (wr_go) state_d = WR;
      end
      WR:      if (m_ready)  state_d = IDLE;
      RD:      if (m_ready)  state_d = RWAIT;
      RWAIT:   if (m_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields load only on leaving IDLE, so they hold until accepted
  always_comb begin
    m_req_d   = (state_d == WR) | (state_d == RD);
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    unique case (1'b1)
      (state_q == IDLE && state_d == WR): begin
        m_we_d    = 1'b1;
        m_addr_d  = {hd_addr, 2'b00};
        m_wdata_d = hd_data;
      end
      (state_q == IDLE && state_d == RD): begin
        m_we_d   = 1'b0;
        m_addr_d = {addr[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: vector table, directed corner sequences and a
// randomized run against a program-order memory model.
module tb_dmem_store_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_read, mem_write;
  logic [31:0] addr, write_data, read_data;
  logic        stall, m_req, m_we, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int n_err = 0;
  int n_chk = 0;

  logic [1:0] rdy_mode;
  logic       rnd_rdy;
  int         rd_lat_min, rd_lat_max;

  assign m_ready = (rdy_mode == 2'd1) | ((rdy_mode == 2'd2) & rnd_rdy);

  dmem_store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .write_data(write_data),
    .read_data(read_data), .stall(stall),
    .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm, input bit ok);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: wait bound expired", nm);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic [31:0] mem  [logic [31:0]];
  logic [31:0] refm [logic [31:0]];
  wr_t         wr_log[$];
  wr_t         exp_wr[$];
  wr_t         we_cur;
  bit          chk_wr = 0;
  bit          rd_busy = 0;
  int          rd_cnt;
  logic [31:0] rd_addr;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (refm.exists(a)) return refm[a];
    return init_val(a);
  endfunction

  initial begin
    m_rvalid = 1'b0;
    m_rdata  = '0;
    rnd_rdy  = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      rd_busy = 0;
    end else if (m_req && m_ready) begin
      if (m_we) begin
        mem[m_addr] = m_wdata;
        wr_log.push_back({m_addr, m_wdata});
        if (chk_wr) begin
          if (exp_wr.size() == 0) begin
            tmo("wr_unexpected", 1'b0);
          end else begin
            we_cur = exp_wr.pop_front();
            chk("wr_order_addr", m_addr, we_cur.a);
            chk("wr_order_data", m_wdata, we_cur.d);
          end
        end
      end else begin
        rd_busy = 1;
        rd_cnt  = $urandom_range(rd_lat_min, rd_lat_max);
        rd_addr = m_addr;
      end
    end
    #1;
    rnd_rdy  = 1'($urandom_range(0, 1));
    m_rvalid = 1'b0;
    m_rdata  = $urandom;
    if (rd_busy) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        m_rvalid = 1'b1;
        m_rdata  = mem_rd(rd_addr);
        rd_busy  = 0;
      end
    end
  end

  // A stalled request must hold its fields until accepted
  logic        hold_v = 1'b0;
  logic        hold_we;
  logic [31:0] hold_a, hold_d;
  always @(posedge clk) begin
    if (hold_v) begin
      chk("hold_ctl", {30'b0, m_req, m_we}, {30'b0, 1'b1, hold_we});
      chk("hold_addr", m_addr, hold_a);
      chk("hold_data", m_wdata, hold_d);
    end
    hold_v  = rst & m_req & ~m_ready;
    hold_we = m_we;
    hold_a  = m_addr;
    hold_d  = m_wdata;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic r, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    rst = r; mem_read = rd; mem_write = wr; addr = a; write_data = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic settle();
    drive(1, 0, 0, 0, 0);
    rdy_mode = 2'd1;
    repeat (12) tick();
  endtask

  task automatic wait_nostall(input string nm);
    int w;
    w = 0;
    mid();
    while (stall && w < 150) begin
      tick();
      mid();
      w++;
    end
    tmo(nm, !stall);
  endtask

  typedef struct {
    logic        r, rd, wr;
    logic [31:0] a, wd;
    logic [1:0]  rdy;
    logic        ex_stall;
    logic [31:0] ex_rdata;
    logic        ex_req;
    logic [31:0] ex_ma;
  } vec_t;

  function automatic vec_t mkv(
    input logic r, input logic rd, input logic wr,
    input logic [31:0] a, input logic [31:0] wd, input logic [1:0] rdy,
    input logic es, input logic [31:0] erd, input logic eq,
    input logic [31:0] ema);
    vec_t v;
    v.r = r; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.rdy = rdy;
    v.ex_stall = es; v.ex_rdata = erd; v.ex_req = eq; v.ex_ma = ema;
    return v;
  endfunction

  vec_t tv[13];

  initial begin
    int base;
    bit ok;
    int n;

    tv[0]  = mkv(0, 0, 0, 32'h00, 32'h0,    0, 0, 0, 0, 32'h0);
    tv[1]  = mkv(0, 1, 0, 32'h80, 32'h0,    0, 0, 0, 0, 32'h0);
    tv[2]  = mkv(0, 0, 1, 32'h10, 32'hDEAD, 0, 0, 0, 0, 32'h0);
    for (int i = 3; i < 8; i++)
      tv[i] = mkv(1, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0);
    tv[8]  = mkv(1, 0, 1, 32'h10, 32'hD000_0010, 0, 0, 0, 0, 32'h0);
    tv[9]  = mkv(1, 0, 1, 32'h14, 32'hD000_0014, 0, 0, 0, 1, 32'h10);
    tv[10] = mkv(1, 0, 1, 32'h18, 32'hD000_0018, 0, 0, 0, 1, 32'h10);
    tv[11] = mkv(1, 0, 1, 32'h1C, 32'hD000_001C, 0, 0, 0, 1, 32'h10);
    tv[12] = mkv(1, 0, 1, 32'h20, 32'hD000_0020, 0, 1, 0, 1, 32'h10);

    rd_lat_min = 1;
    rd_lat_max = 1;
    rdy_mode   = 2'd0;
    drive(0, 0, 0, 0, 0);
    tick();
    mid();
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(tv[i].r, tv[i].rd, tv[i].wr, tv[i].a, tv[i].wd);
      rdy_mode = tv[i].rdy;
      mid();
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tv[i].ex_stall));
      chk($sformatf("v%0d_rdata", i), read_data, tv[i].ex_rdata);
      chk($sformatf("v%0d_req", i), 32'(m_req), 32'(tv[i].ex_req));
      chk($sformatf("v%0d_maddr", i), m_addr, tv[i].ex_ma);
      tick();
    end

    // Drain: the stalled 5th store enters, then all five write in order
    base = wr_log.size();
    rdy_mode = 2'd1;
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      mid();
      if (!stall) ok = 1;
      tick();
    end
    tmo("fill_enqueue", ok);
    mem_write = 1'b0;
    for (int k = 0; k < 40 && wr_log.size() < base + 5; k++) tick();
    tmo("fill_drain", wr_log.size() >= base + 5);
    for (int i = 0; i < 5 && base + i < wr_log.size(); i++) begin
      chk("fill_addr", wr_log[base+i].a, 32'h10 + 32'(4 * i));
      chk("fill_data", wr_log[base+i].d, 32'hD000_0010 + 32'(4 * i));
    end
    settle();

    // Two stores to one address, then a load of it
    rdy_mode = 2'd0;
    drive(1, 0, 1, 32'h40, 32'h0000_AAAA);
    tick();
    drive(1, 0, 1, 32'h40, 32'h0000_BBBB);
    tick();
    drive(1, 1, 0, 32'h40, 32'h0);
    mid();
`ifdef STORE_FORWARD_EN
    chk("fwd_stall", 32'(stall), 32'd0);
    chk("fwd_rdata", read_data, 32'h0000_BBBB);
`else
    chk("nofwd_stall", 32'(stall), 32'd1);
    rdy_mode = 2'd1;
    tick();
    wait_nostall("nofwd_wait");
    chk("nofwd_rdata", read_data, 32'h0000_BBBB);
`endif
    tick();
    settle();

    // Load miss with idle FSM and ready memory
    mem[32'h80] = 32'h0000_1234;
    drive(1, 1, 0, 32'h80, 32'h0);
    n = 0;
    mid();
    while (stall && n < 20) begin
      n++;
      tick();
      mid();
    end
    chk("miss_stall_cycles", 32'(n), 32'd3);
    chk("miss_rdata", read_data, 32'h0000_1234);
    tick();
    settle();

    // Load arriving while a write is held
    rdy_mode = 2'd0;
    drive(1, 0, 1, 32'h100, 32'h0100_CAFE);
    tick();
    drive(1, 1, 0, 32'h104, 32'h0);
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("held_req", {30'b0, m_req, m_we}, 32'd3);
      chk("held_addr", m_addr, 32'h100);
      chk("held_data", m_wdata, 32'h0100_CAFE);
      chk("held_stall", 32'(stall), 32'd1);
      tick();
    end
    base = wr_log.size();
    rdy_mode = 2'd1;
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      mid();
      if (m_req && !m_we) begin
        ok = 1;
        chk("rd_after_wr", 32'(wr_log.size()), 32'(base + 1));
        chk("rd_addr", m_addr, 32'h104);
      end
      tick();
    end
    tmo("rd_issue", ok);
    wait_nostall("held_load_wait");
    chk("held_load_rdata", read_data, init_val(32'h104));
    tick();
    settle();

    // Reset with two stores still buffered
    rdy_mode = 2'd0;
    drive(1, 0, 1, 32'h200, 32'h0200_0001);
    tick();
    drive(1, 0, 1, 32'h204, 32'h0200_0002);
    tick();
`ifdef STORE_FORWARD_EN
    rd_lat_min = 6;
    rd_lat_max = 6;
    drive(1, 0, 1, 32'h208, 32'h0200_0003);
    tick();
    drive(1, 1, 0, 32'h300, 32'h0);
    tick();
    rdy_mode = 2'd1;
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      mid();
      if (m_req && !m_we) ok = 1;
      tick();
    end
    tmo("reach_rwait", ok);
`endif
    drive(0, 0, 0, 0, 0);
    base = wr_log.size();
    mid();
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_rdata", read_data, 32'd0);
    tick();
    rst = 1'b1;
    rdy_mode = 2'd1;
    rd_lat_min = 1;
    rd_lat_max = 1;
    mid();
    chk("rst_mid_req", 32'(m_req), 32'd0);
    tick();
    repeat (10) tick();
    chk("rst_no_writes", 32'(wr_log.size()), 32'(base));
    drive(1, 1, 0, 32'h204, 32'h0);
    tick();
    wait_nostall("rst_load_wait");
    chk("rst_discarded", read_data, init_val(32'h204));
    tick();
    settle();

    // Randomized run against program-order model
    rd_lat_min = 1;
    rd_lat_max = 3;
    rdy_mode   = 2'd2;
    chk_wr     = 1;
    for (int k = 0; k < 300; k++) begin
      int          op;
      logic [31:0] a, wa, d;
      op = $urandom_range(0, 2);
      a  = 32'h400 + 32'($urandom_range(0, 11)) * 4 +
           32'($urandom_range(0, 3));
      wa = a & 32'hFFFF_FFFC;
      d  = $urandom;
      drive(1, op == 1, op == 2, a, d);
      wait_nostall("rnd_wait");
      if (op == 1) chk("rnd_load", read_data, ref_rd(wa));
      if (op == 0) chk("rnd_idle_rdata", read_data, 32'd0);
      if (op == 2) begin
        refm[wa] = d;
        exp_wr.push_back({wa, d});
      end
      tick();
    end
    drive(1, 0, 0, 0, 0);
    rdy_mode = 2'd1;
    for (int k = 0; k < 60 && exp_wr.size() != 0; k++) tick();
    tmo("rnd_drain", exp_wr.size() == 0);
    repeat (3) tick();
    chk_wr = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Data-memory front end between the single-cycle MIPS datapath (consumes `alu_result`, `write_data`, `mem_write`; produces `read_data`) and a slower data memory with a request/ready handshake. Stores are posted into a small in-order FIFO and retired to memory in the background. Loads that hit a buffered store are forwarded with zero stall; other loads stall the core until memory returns data. Sits directly downstream of the datapath in place of a zero-latency dmem.

## Interface
- `DEPTH`, 4: store FIFO entries (power of two, ≥2)
- `clk  in  1`: clock, all state on rising edge
- `rst  in  1`: synchronous reset, active-low (reset when `rst`=0)
- `mem_read  in  1`: core load this cycle
- `mem_write  in  1`: core store this cycle (never together with `mem_read`)
- `addr  in  32`: byte address from `alu_result`; word-aligned, bits [1:0] ignored
- `write_data  in  32`: store data
- `read_data  out  32`: load data, valid in a cycle with `mem_read`=1 and `stall`=0
- `stall  out  1`: combinational; core must hold PC and all inputs while 1
- `m_req  out  1`: memory request, registered
- `m_we  out  1`: 1 = write, 0 = read
- `m_addr  out  32`: word address {addr[31:2],2'b00}
- `m_wdata  out  32`: write data
- `m_ready  in  1`: request accepted on cycle `m_req`&`m_ready`
- `m_rvalid  in  1`: read data valid, ≥1 cycle after read acceptance
- `m_rdata  in  32`: read data

## Operation
- FIFO holds {addr[31:2], data}; `count` 0..DEPTH; head = oldest entry.
- Store enqueue: `mem_write`=1 and count<DEPTH. Full is judged on count before any same-cycle pop; no full-bypass.
- `stall` = (`mem_write` & full) | (`mem_read` & load not satisfied this cycle).
- Forward hit (with macro): `mem_read` and any entry matches addr[31:2]. Return the youngest match, combinationally, with `stall`=0.
- Load miss: latch `pend`=1, then stall until the data is delivered.
- FSM states: IDLE, WR, RD, RWAIT.
  - IDLE → RD if `pend` and load not yet done. Loads have priority over writes.
  - IDLE → WR otherwise, if count>0.
  - WR presents the head entry (`m_we`=1). On `m_ready`: pop the head, go to IDLE.
  - RD presents `m_we`=0 at the load address. On `m_ready`: go to RWAIT.
  - RWAIT on `m_rvalid`: `ld_data`←`m_rdata`, `ld_done`←1, go to IDLE.
- Completion: a cycle with `mem_read` and `ld_done`=1 gives `read_data`=`ld_data` and `stall`=0. `pend` and `ld_done` clear at the next edge.
- Request stability: while `m_req`=1 and `m_ready`=0, `m_we`, `m_addr` and `m_wdata` must not change. A load arriving during WR waits for that write to be accepted.
- `m_req` is 0 in IDLE and RWAIT.
- `read_data` = 0 when `mem_read`=0.
- Mid-operation reset: FIFO emptied (buffered stores discarded), FSM to IDLE, `pend`/`ld_done` cleared. The memory side must be reset alongside.

## Timing
- Reset values: `m_req`=0, `m_we`=0, `m_addr`=0, `m_wdata`=0, count=0, state IDLE. `stall`=0 and `read_data`=0 while `rst`=0.
- Store, not full: 0 stall cycles. Earliest memory write is presented 1 cycle after enqueue.
- Each write occupies ≥2 cycles (WR, then IDLE), giving a drain rate of ≤1 store per 2 cycles.
- Forward hit: 0 stall cycles.
- Load miss, FSM idle, memory ready, `m_rvalid` 1 cycle after acceptance: `stall`=1 for 3 cycles, data on the 4th. Each wait cycle on `m_ready` or `m_rvalid` adds 1 stall cycle.
- Simultaneous enqueue and pop: count unchanged; the new entry is written at the tail.

## Configuration
- `STORE_FORWARD_EN` defined:
  - address compare and forwarding as above.
- Not defined:
  - no compare logic;
  - every load waits in IDLE until count=0, then issues RD. Stall cycles include the full drain time.
  - Store path is unchanged.

## Test plan
- Reset with `rst`=0 for 2 cycles → `m_req`=0, `stall`=0, count=0; release, idle for 5 cycles → no `m_req`.
- Stores to 0x10, 0x14, 0x18, 0x1C, 0x20 back-to-back, `m_ready`=0 → no stall for the first 4, `stall`=1 on the 5th. Raise `m_ready` → writes appear in order at 0x10…0x20 with `m_wdata` matching.
- Store 0xAAAA to 0x40, then 0xBBBB to 0x40, then load 0x40 (macro on, `m_ready`=0) → `read_data`=0xBBBB, `stall`=0.
- Load 0x80 with FIFO empty, memory ready, `m_rvalid` 1 cycle later with 0x1234 → `stall` high exactly 3 cycles, then `read_data`=0x1234.
- Load miss issued while WR is held by `m_ready`=0 for 3 cycles → `m_addr`/`m_wdata` stable throughout; read presented only after the write is accepted.
- Assert `rst`=0 during RWAIT with 2 entries buffered → next cycle `m_req`=0, count=0, no further memory writes.
